// File: rtl/udp_packet_encoder_pkg.sv
// Shared definitions for the UDP datagram encoder.
// Contents: protocol constants, FSM state type, and a 16-bit
// ones-complement adder with end-around carry used by the checksum fold.
package udp_packet_encoder_pkg;

    localparam logic [7:0] UDP_PROTO     = 8'h11;
    localparam int         UDP_HDR_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HDR0    = 3'd2,
        ST_HDR1    = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Ones-complement 16-bit add: the carry out of bit 15 wraps into bit 0.
    // When a carry occurs the low 16 bits are at most 16'hFFFE, so the
    // wrap-around add can never carry again.
    function automatic logic [15:0] ones_add16(input logic [15:0] a,
                                               input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

endpackage

// File: rtl/udp_csum_accum.sv
// Ones-complement checksum accumulator.
// clr loads 'init' (the pre-summed pseudo-header/header terms); add_en adds
// both 16-bit halves of 'word'. Both may be active in the same cycle.
// csum_next is the folded and inverted checksum of the value the
// accumulator will hold after this cycle, so the owner can capture the
// final checksum on the same edge that the last word is added.
// Ports: clk, reset (async, active low), clr, init[31:0], add_en,
//        word[31:0], csum_next[15:0].
module udp_csum_accum
    import udp_packet_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [31:0] init,
    input  logic        add_en,
    input  logic [31:0] word,
    output logic [15:0] csum_next
);

    logic [31:0] acc_r;
    logic [31:0] base_s;
    logic [31:0] acc_nxt_s;
    logic [16:0] fold1_s;
    logic [15:0] folded_s;

    // Next accumulator value: restart from init or continue, then add the word halves.
    always_comb begin
        base_s    = acc_r;
        acc_nxt_s = acc_r;
        if (clr) begin
            base_s = init;
        end else begin
            base_s = acc_r;
        end
        if (add_en) begin
            acc_nxt_s = base_s + {16'd0, word[31:16]} + {16'd0, word[15:0]};
        end else begin
            acc_nxt_s = base_s;
        end
    end

    // First fold adds the two halves; the second fold (end-around carry) absorbs its carry.
    always_comb begin
        fold1_s   = {1'b0, acc_nxt_s[31:16]} + {1'b0, acc_nxt_s[15:0]};
        folded_s  = ones_add16(fold1_s[15:0], {15'd0, fold1_s[16]});
        csum_next = ~folded_s;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= 32'd0;
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

endmodule

// File: rtl/udp_packet_encoder.sv
// UDP datagram encoder: buffers up to MAX_WORDS payload words, accumulates
// the RFC 768 checksum (pseudo-header + UDP header + payload), then emits
// {src_port,dest_port}, {length,checksum} and the buffered payload.
// Ports:
//   clk, reset (async, active low)
//   src_ip, dest_ip      - pseudo-header addresses, sampled on start
//   src_port, dest_port  - UDP ports, sampled on start
//   len_in               - payload bytes, saturated to 4*MAX_WORDS
//   data, data_av        - payload word stream (first byte in [31:24])
//   no_chksum            - send checksum 0x0000
//   start                - begin (or abort and restart) a datagram
//   pkg_data, wr_en      - output word stream
//   fin                  - one-cycle pulse after the last output word
//   checksum_out, len_out- transmitted checksum and UDP length
module udp_packet_encoder
    import udp_packet_encoder_pkg::*;
#(
    parameter int MAX_WORDS = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] src_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic [15:0] len_in,
    input  logic [31:0] data,
    input  logic        no_chksum,
    input  logic        start,
    input  logic        data_av,
    output logic [31:0] pkg_data,
    output logic        wr_en,
    output logic        fin,
    output logic [15:0] checksum_out,
    output logic [15:0] len_out
);

    localparam int              CW        = $clog2(MAX_WORDS + 1);
    localparam int              AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [15:0]     MAX_BYTES = 16'(4 * MAX_WORDS);
    localparam logic [CW-1:0]   K_ONE     = CW'(1);
    localparam logic [CW-1:0]   K_ZERO    = CW'(0);

    state_t          state_r;
    logic [31:0]     pkg_data_r;
    logic            wr_en_r;
    logic            fin_r;
    logic [15:0]     checksum_out_r;
    logic [15:0]     len_out_r;
    logic [15:0]     len_r;
    logic [CW-1:0]   n_r;
    logic [CW-1:0]   k_r;
    logic [15:0]     src_port_r;
    logic [15:0]     dest_port_r;
    logic            no_chksum_r;
    logic [31:0]     pay_buf_r [MAX_WORDS];

    logic [15:0]     len_sat_s;
    logic [16:0]     len_plus3_s;
    logic [CW-1:0]   n_new_s;
    logic [15:0]     udp_len_s;
    logic [31:0]     init_s;
    logic [15:0]     len_cur_s;
    logic [CW-1:0]   n_cur_s;
    logic [CW-1:0]   k_cur_s;
    logic [15:0]     sport_cur_s;
    logic [15:0]     dport_cur_s;
    logic            nochk_cur_s;
    logic            coll_s;
    logic            take_s;
    logic            last_s;
    logic [CW-1:0]   k_next_s;
    logic [31:0]     mask_s;
    logic [31:0]     word_s;
    logic [15:0]     csum_next_s;
    logic [15:0]     csum_final_s;

    // Length saturation, word count and the header/pseudo-header partial sum.
    // The IP addresses only feed this sum, so they are consumed on start and
    // never need to be stored.
    always_comb begin
        if (len_in > MAX_BYTES) begin
            len_sat_s = MAX_BYTES;
        end else begin
            len_sat_s = len_in;
        end
        len_plus3_s = {1'b0, len_sat_s} + 17'd3;
        n_new_s     = CW'(len_plus3_s >> 2);
        udp_len_s   = len_sat_s + 16'(UDP_HDR_BYTES);
        init_s      = {16'd0, src_ip[31:16]} + {16'd0, src_ip[15:0]}
                    + {16'd0, dest_ip[31:16]} + {16'd0, dest_ip[15:0]}
                    + {24'd0, UDP_PROTO}
                    + {16'd0, udp_len_s} + {16'd0, udp_len_s}
                    + {16'd0, src_port} + {16'd0, dest_port};
    end

    // Datagram context for this cycle: on start the fresh inputs apply, so a
    // word arriving with start is treated as word 0 of the new datagram.
    always_comb begin
        if (start) begin
            len_cur_s   = len_sat_s;
            n_cur_s     = n_new_s;
            k_cur_s     = K_ZERO;
            sport_cur_s = src_port;
            dport_cur_s = dest_port;
            nochk_cur_s = no_chksum;
            coll_s      = 1'b1;
        end else begin
            len_cur_s   = len_r;
            n_cur_s     = n_r;
            k_cur_s     = k_r;
            sport_cur_s = src_port_r;
            dport_cur_s = dest_port_r;
            nochk_cur_s = no_chksum_r;
            coll_s      = (state_r == ST_COLLECT);
        end
    end

    // Word acceptance and zeroing of bytes past the payload end in the last word.
    always_comb begin
        take_s = coll_s && data_av && (k_cur_s < n_cur_s);
        last_s = (k_cur_s == (n_cur_s - K_ONE));
        if (take_s) begin
            k_next_s = k_cur_s + K_ONE;
        end else begin
            k_next_s = k_cur_s;
        end
        case (len_cur_s[1:0])
            2'd1:    mask_s = 32'hFF00_0000;
            2'd2:    mask_s = 32'hFFFF_0000;
            2'd3:    mask_s = 32'hFFFF_FF00;
            default: mask_s = 32'hFFFF_FFFF;
        endcase
        if (last_s) begin
            word_s = data & mask_s;
        end else begin
            word_s = data;
        end
    end

    udp_csum_accum u_csum (
        .clk       (clk),
        .reset     (reset),
        .clr       (start),
        .init      (init_s),
        .add_en    (take_s),
        .word      (word_s),
        .csum_next (csum_next_s)
    );

    // Transmitted checksum: disabled -> 0x0000; a computed zero goes out as 0xFFFF.
    always_comb begin
        if (nochk_cur_s) begin
            csum_final_s = 16'h0000;
        end else if (csum_next_s == 16'h0000) begin
            csum_final_s = 16'hFFFF;
        end else begin
            csum_final_s = csum_next_s;
        end
    end

    // Sequencer: collection, header/payload emission and the fin pulse.
    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            pkg_data_r     <= 32'd0;
            wr_en_r        <= 1'b0;
            fin_r          <= 1'b0;
            checksum_out_r <= 16'd0;
            len_out_r      <= 16'd0;
            len_r          <= 16'd0;
            n_r            <= K_ZERO;
            k_r            <= K_ZERO;
            src_port_r     <= 16'd0;
            dest_port_r    <= 16'd0;
            no_chksum_r    <= 1'b0;
        end else if (start || (state_r == ST_COLLECT)) begin
            if (start) begin
                len_r       <= len_sat_s;
                n_r         <= n_new_s;
                len_out_r   <= udp_len_s;
                src_port_r  <= src_port;
                dest_port_r <= dest_port;
                no_chksum_r <= no_chksum;
            end else begin
                len_r       <= len_r;
            end
            k_r   <= k_next_s;
            fin_r <= 1'b0;
            if (k_next_s == n_cur_s) begin
                state_r        <= ST_HDR0;
                wr_en_r        <= 1'b1;
                pkg_data_r     <= {sport_cur_s, dport_cur_s};
                checksum_out_r <= csum_final_s;
            end else begin
                state_r    <= ST_COLLECT;
                wr_en_r    <= 1'b0;
                pkg_data_r <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_HDR0: begin
                    state_r    <= ST_HDR1;
                    wr_en_r    <= 1'b1;
                    fin_r      <= 1'b0;
                    pkg_data_r <= {len_out_r, checksum_out_r};
                end
                ST_HDR1: begin
                    if (n_r == K_ZERO) begin
                        state_r    <= ST_DONE;
                        wr_en_r    <= 1'b0;
                        fin_r      <= 1'b1;
                        pkg_data_r <= 32'd0;
                    end else begin
                        state_r    <= ST_PAYLOAD;
                        wr_en_r    <= 1'b1;
                        fin_r      <= 1'b0;
                        pkg_data_r <= pay_buf_r[0];
                        k_r        <= K_ONE;
                    end
                end
                ST_PAYLOAD: begin
                    if (k_r == n_r) begin
                        state_r    <= ST_DONE;
                        wr_en_r    <= 1'b0;
                        fin_r      <= 1'b1;
                        pkg_data_r <= 32'd0;
                    end else begin
                        state_r    <= ST_PAYLOAD;
                        wr_en_r    <= 1'b1;
                        fin_r      <= 1'b0;
                        pkg_data_r <= pay_buf_r[k_r[AW-1:0]];
                        k_r        <= k_r + K_ONE;
                    end
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    wr_en_r    <= 1'b0;
                    fin_r      <= 1'b0;
                    pkg_data_r <= 32'd0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wr_en_r    <= 1'b0;
                    fin_r      <= 1'b0;
                    pkg_data_r <= 32'd0;
                end
            endcase
        end
    end

    // Payload buffer write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
                pay_buf_r[i] <= 32'd0;
            end
        end else if (take_s) begin
            pay_buf_r[k_cur_s[AW-1:0]] <= word_s;
        end else begin
            pay_buf_r[0] <= pay_buf_r[0];
        end
    end

    assign pkg_data     = pkg_data_r;
    assign wr_en        = wr_en_r;
    assign fin          = fin_r;
    assign checksum_out = checksum_out_r;
    assign len_out      = len_out_r;

endmodule

// File: tb/tb_udp_packet_encoder.sv
// Directed bench for udp_packet_encoder: a table of datagrams with
// hand-computed checksums, plus hand-written sequences for length
// saturation, restart during collection and reset during payload output.
module tb_udp_packet_encoder;

    logic        clk;
    logic        reset;
    logic [31:0] src_ip;
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [15:0] len_in;
    logic [31:0] data;
    logic        no_chksum;
    logic        start;
    logic        data_av;
    logic [31:0] pkg_data;
    logic        wr_en;
    logic        fin;
    logic [15:0] checksum_out;
    logic [15:0] len_out;

    udp_packet_encoder #(.MAX_WORDS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_ip       (src_ip),
        .dest_ip      (dest_ip),
        .src_port     (src_port),
        .dest_port    (dest_port),
        .len_in       (len_in),
        .data         (data),
        .no_chksum    (no_chksum),
        .start        (start),
        .data_av      (data_av),
        .pkg_data     (pkg_data),
        .wr_en        (wr_en),
        .fin          (fin),
        .checksum_out (checksum_out),
        .len_out      (len_out)
    );

    typedef struct {
        logic [31:0]      src_ip;
        logic [31:0]      dest_ip;
        logic [15:0]      src_port;
        logic [15:0]      dest_port;
        logic [15:0]      len_in;
        logic             no_chksum;
        logic             gap;
        int               nwords;
        logic [3:0][31:0] in_w;
        logic [3:0][31:0] exp_w;
        logic [15:0]      exp_csum;
        logic [15:0]      exp_len;
    } vec_t;

    vec_t        vecs [5];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fin_cnt  = 0;
    int          fin_cyc  = -1;
    logic [31:0] cap_q [$];
    int          cap_cyc_q [$];
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            cap_q.push_back(pkg_data);
            cap_cyc_q.push_back(cyc);
        end
        if (fin === 1'b1) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_cap();
        cap_q.delete();
        cap_cyc_q.delete();
        exp_q.delete();
        fin_cnt = 0;
        fin_cyc = -1;
    endtask

    task automatic wait_fin();
        for (int t = 0; t < 200 && fin_cnt == 0; t++) begin
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    // drive_cyc: cycle in which the last accepted word (or bare start) was driven
    task automatic check_stream(input string tag, input int drive_cyc);
        chk({tag, "/word_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) chk($sformatf("%s/word%0d", tag, i), cap_q[i], exp_q[i]);
        end
        if (cap_cyc_q.size() > 0) begin
            chk({tag, "/first_wr_cycle"}, cap_cyc_q[0], drive_cyc + 1);
            chk({tag, "/last_wr_cycle"}, cap_cyc_q[$], drive_cyc + exp_q.size());
        end
        chk({tag, "/fin_cycle"}, fin_cyc, drive_cyc + exp_q.size() + 1);
        chk({tag, "/fin_pulses"}, fin_cnt, 1);
    endtask

    task automatic send(input string tag, input vec_t v);
        int drive_cyc;
        clear_cap();
        @(posedge clk); #1;
        src_ip    = v.src_ip;
        dest_ip   = v.dest_ip;
        src_port  = v.src_port;
        dest_port = v.dest_port;
        len_in    = v.len_in;
        no_chksum = v.no_chksum;
        start     = 1'b1;
        data_av   = (v.nwords > 0);
        data      = v.in_w[0];
        drive_cyc = cyc;
        for (int i = 1; i < v.nwords; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 1 && v.gap) begin
                data_av = 1'b0;
                @(posedge clk); #1;
            end
            data_av   = 1'b1;
            data      = v.in_w[i];
            drive_cyc = cyc;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        data_av = 1'b0;
        data    = 32'h0;
        exp_q.push_back({v.src_port, v.dest_port});
        exp_q.push_back({v.exp_len, v.exp_csum});
        for (int i = 0; i < v.nwords; i++) exp_q.push_back(v.exp_w[i]);
        wait_fin();
        check_stream(tag, drive_cyc);
        chk({tag, "/checksum_out"}, {16'h0, checksum_out}, {16'h0, v.exp_csum});
        chk({tag, "/len_out"}, {16'h0, len_out}, {16'h0, v.exp_len});
    endtask

    initial begin
        int drive_cyc;
        // Hello World, gap after word 0, garbage in the byte past the end
        vecs[0] = '{32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'd11, 1'b0, 1'b1, 3,
                    {32'h0, 32'h726c64aa, 32'h6f20576f, 32'h48656c6c},
                    {32'h0, 32'h726c6400, 32'h6f20576f, 32'h48656c6c},
                    16'h2560, 16'h0013};
        vecs[1] = vecs[0];
        vecs[1].no_chksum = 1'b1;
        vecs[1].exp_csum  = 16'h0000;
        // Empty payload: headers only, length 8
        vecs[2] = '{32'h9801331b, 32'h980e5e4b, 16'ha08f, 16'h2694, 16'd0, 1'b0, 1'b0, 0,
                    128'h0, 128'h0, 16'h7744, 16'h0008};
        // Sum folds to 0xFFFF -> computed checksum 0 -> transmitted as FFFF
        vecs[3] = '{32'h0, 32'h0, 16'h0000, 16'h0000, 16'd4, 1'b0, 1'b0, 1,
                    {96'h0, 32'hffd60000}, {96'h0, 32'hffd60000}, 16'hffff, 16'h000c};
        // 5-byte payload: three trailing bytes of word 1 forced to zero
        vecs[4] = '{32'h0a000001, 32'h0a000002, 16'h1234, 16'h5678, 16'd5, 1'b0, 1'b0, 2,
                    {64'h0, 32'hcafebabe, 32'hdeadbeef}, {64'h0, 32'hca000000, 32'hdeadbeef},
                    16'h1b87, 16'h000d};

        reset = 1'b0; src_ip = 32'h0; dest_ip = 32'h0; src_port = 16'h0; dest_port = 16'h0;
        len_in = 16'h0; data = 32'h0; no_chksum = 1'b0; start = 1'b0; data_av = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset/wr_en", {31'h0, wr_en}, 32'h0);
        chk("reset/fin", {31'h0, fin}, 32'h0);
        chk("reset/pkg_data", pkg_data, 32'h0);
        chk("reset/checksum_out", {16'h0, checksum_out}, 32'h0);
        chk("reset/len_out", {16'h0, len_out}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 5; i++) send($sformatf("vec%0d", i), vecs[i]);

        // Length saturation: 70 bytes -> 64 bytes, 16 words; a 17th word is ignored
        clear_cap();
        @(posedge clk); #1;
        src_ip = 32'hc0a80001; dest_ip = 32'hc0a80002; src_port = 16'h0400; dest_port = 16'h0800;
        len_in = 16'd70; no_chksum = 1'b1; start = 1'b1; data_av = 1'b1; data = 32'h1000_0000;
        drive_cyc = cyc;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            data  = 32'h1000_0000 + 32'(i);
            if (i < 16) drive_cyc = cyc;
        end
        @(posedge clk); #1;
        data_av = 1'b0;
        exp_q.push_back(32'h0400_0800);
        exp_q.push_back(32'h0048_0000);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000_0000 + 32'(i));
        wait_fin();
        check_stream("sat", drive_cyc);
        chk("sat/checksum_out", {16'h0, checksum_out}, 32'h0);
        chk("sat/len_out", {16'h0, len_out}, 32'h0000_0048);

        // Restart in COLLECT: one word of a 2-word datagram, then Hello World
        @(posedge clk); #1;
        src_ip = vecs[4].src_ip; dest_ip = vecs[4].dest_ip; src_port = vecs[4].src_port;
        dest_port = vecs[4].dest_port; len_in = vecs[4].len_in; no_chksum = 1'b0;
        start = 1'b1; data_av = 1'b1; data = 32'hdeadbeef;
        @(posedge clk); #1;
        start = 1'b0; data_av = 1'b0;
        send("restart", vecs[0]);

        // Reset while the payload is being emitted
        clear_cap();
        @(posedge clk); #1;
        src_ip = vecs[4].src_ip; dest_ip = vecs[4].dest_ip; src_port = vecs[4].src_port;
        dest_port = vecs[4].dest_port; len_in = vecs[4].len_in; no_chksum = 1'b0;
        start = 1'b1; data_av = 1'b1; data = 32'hdeadbeef;
        @(posedge clk); #1;
        start = 1'b0; data = 32'hcafebabe;
        @(posedge clk); #1;
        data_av = 1'b0;
        for (int t = 0; t < 50 && cap_q.size() < 3; t++) begin
            @(negedge clk);
            #1;
        end
        chk("rstpay/reached_payload", cap_q.size(), 3);
        reset = 1'b0;
        #1;
        chk("rstpay/wr_en", {31'h0, wr_en}, 32'h0);
        chk("rstpay/fin", {31'h0, fin}, 32'h0);
        chk("rstpay/checksum_out", {16'h0, checksum_out}, 32'h0);
        chk("rstpay/len_out", {16'h0, len_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_cap();
        // Words without a start must be ignored
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            data_av = 1'b1;
            data    = 32'h5555_0000 + 32'(i);
        end
        @(posedge clk); #1;
        data_av = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("nostart/no_output", cap_q.size(), 0);
        chk("nostart/no_fin", fin_cnt, 0);

        send("after_reset", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
